// File: rtl/sp_pkg.sv
// Shared definitions for the SP core operand-fetch and writeback units.
package sp_pkg;

  // Default widths: data word, register index and opaque control field.
  localparam int SP_DW  = 16;
  localparam int SP_RW  = 4;
  localparam int SP_OPW = 8;

  // Operand-fetch control state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // holding register empty
    WAIT  = 2'd1,  // instruction captured, operands not yet latched
    READY = 2'd2   // operand bundle presented to execute
  } state_t;

endpackage

// File: rtl/sp_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register.
// A set and a clear of the same index on the same edge leaves the bit set,
// because the clear always belongs to an older write than the set.
module sp_scoreboard
  import sp_pkg::*;
#(
  parameter int RW = SP_RW
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              set_en,
  input  logic [RW-1:0]     set_idx,
  input  logic              clr_en,
  input  logic [RW-1:0]     clr_idx,
  output logic [2**RW-1:0]  pending
);

  localparam int NREG = 2**RW;

  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  // Decode the set and clear ports into one-hot masks.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
  end

  // Pending vector: clear first, then set, so set wins on a collision.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pending <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: rtl/sp_operand_fetch.sv
// Operand fetch for the SP core: captures a decoded instruction, waits out
// RAW/WAW hazards against the pending-write scoreboard, reads the register
// file and presents the operand bundle to execute over valid/ready.
module sp_operand_fetch
  import sp_pkg::*;
#(
  parameter int DW  = SP_DW,
  parameter int RW  = SP_RW,
  parameter int OPW = SP_OPW
) (
  input  logic            clk,
  input  logic            Reset_n,
  // decoded instruction
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RW-1:0]   in_nA,
  input  logic [RW-1:0]   in_nB,
  input  logic [RW-1:0]   in_nC,
  input  logic [2:0]      in_use,
  input  logic [RW-1:0]   in_nD,
  input  logic            in_wr,
  input  logic [OPW-1:0]  in_op,
  // register-file read ports
  output logic [RW-1:0]   rf_nA,
  output logic [RW-1:0]   rf_nB,
  output logic [RW-1:0]   rf_nC,
  input  logic [DW-1:0]   rf_A,
  input  logic [DW-1:0]   rf_B,
  input  logic [DW-1:0]   rf_C,
  // writeback (shared with the register-file write port)
  input  logic [RW-1:0]   wb_nD,
  input  logic            wb_WE,
  // operand bundle to execute
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_A,
  output logic [DW-1:0]   out_B,
  output logic [DW-1:0]   out_C,
  output logic [RW-1:0]   out_nD,
  output logic            out_wr,
  output logic [OPW-1:0]  out_op
);

  state_t state;
  state_t state_nxt;

  // Holding register for the instruction waiting on its operands.
  logic [RW-1:0]   h_nA, h_nB, h_nC, h_nD;
  logic [2:0]      h_use;
  logic            h_wr;
  logic [OPW-1:0]  h_op;

  logic [2**RW-1:0] pending;
  logic             accept;
  logic             dispatch;
  logic             hazard;
  logic             launch;

  // A new instruction can enter when empty or when the bundle leaves this cycle.
  assign in_ready  = Reset_n && ((state == IDLE) || ((state == READY) && out_ready));
  assign accept    = in_valid && in_ready;
  assign dispatch  = (state == READY) && out_ready;
  assign out_valid = (state == READY);
  assign launch    = (state == WAIT) && !hazard;

  // Read indices come straight from the holding register, stable across WAIT.
  assign rf_nA = h_nA;
  assign rf_nB = h_nB;
  assign rf_nC = h_nC;

  // Hazard check against this cycle's scoreboard; a same-cycle writeback
  // still stalls because the register file updates only after the edge.
  always_comb begin
    hazard = 1'b0;
    if (h_use[0] && pending[h_nA]) hazard = 1'b1;
    if (h_use[1] && pending[h_nB]) hazard = 1'b1;
    if (h_use[2] && pending[h_nC]) hazard = 1'b1;
    if (h_wr && pending[h_nD])     hazard = 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (!hazard) state_nxt = READY;
      READY:   if (out_ready) state_nxt = accept ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Capture the accepted instruction, even on an edge that dispatches the previous one.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      h_nA  <= '0;
      h_nB  <= '0;
      h_nC  <= '0;
      h_use <= '0;
      h_nD  <= '0;
      h_wr  <= 1'b0;
      h_op  <= '0;
    end else if (accept) begin
      h_nA  <= in_nA;
      h_nB  <= in_nB;
      h_nC  <= in_nC;
      h_use <= in_use;
      h_nD  <= in_nD;
      h_wr  <= in_wr;
      h_op  <= in_op;
    end
  end

  // Latch operands and destination once the hazard clears; held through backpressure.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_A  <= '0;
      out_B  <= '0;
      out_C  <= '0;
      out_nD <= '0;
      out_wr <= 1'b0;
      out_op <= '0;
    end else if (launch) begin
      out_A  <= rf_A;
      out_B  <= rf_B;
      out_C  <= rf_C;
      out_nD <= h_nD;
      out_wr <= h_wr;
      out_op <= h_op;
    end
  end

  // A destination becomes pending when its instruction leaves for execute.
  sp_scoreboard #(.RW(RW)) u_sb (
    .clk     (clk),
    .Reset_n (Reset_n),
    .set_en  (dispatch && out_wr),
    .set_idx (out_nD),
    .clr_en  (wb_WE),
    .clr_idx (wb_nD),
    .pending (pending)
  );

endmodule

// File: tb/tb_sp_operand_fetch.sv
// Testbench for sp_operand_fetch: a program-order reference model predicts
// each bundle at accept time; a monitor compares bundles as they dispatch.
module tb_sp_operand_fetch;
  import sp_pkg::*;

  localparam int DW  = SP_DW;
  localparam int RW  = SP_RW;
  localparam int OPW = SP_OPW;
  localparam int NR  = 2**SP_RW;

  logic            clk;
  logic            Reset_n;
  logic            in_valid, in_ready;
  logic [RW-1:0]   in_nA, in_nB, in_nC, in_nD;
  logic [2:0]      in_use;
  logic            in_wr;
  logic [OPW-1:0]  in_op;
  logic [RW-1:0]   rf_nA, rf_nB, rf_nC;
  logic [DW-1:0]   rf_A, rf_B, rf_C;
  logic [RW-1:0]   wb_nD;
  logic            wb_WE;
  logic            out_valid, out_ready;
  logic [DW-1:0]   out_A, out_B, out_C;
  logic [RW-1:0]   out_nD;
  logic            out_wr;
  logic [OPW-1:0]  out_op;

  typedef struct {
    logic [RW-1:0]  nD;
    logic [2:0]     mask;
    logic           wr;
    logic [OPW-1:0] op;
    logic [DW-1:0]  a, b, c, wdata;
  } exp_t;

  typedef struct {
    logic [RW-1:0] idx;
    logic [DW-1:0] data;
    int            avail;
  } wb_t;

  typedef struct {
    int idx;
    bit spur;
  } wreq_t;

  exp_t          exp_q[$];   // bundles expected in program order
  wb_t           pend_wb[$]; // dispatched writes awaiting writeback
  wreq_t         req_q[$];   // directed writeback requests
  logic [DW-1:0] rf[NR];     // register file as seen by the DUT
  logic [DW-1:0] arch[NR];   // program-order architectural values
  int            total, bad, cyc, wb_count;
  bit            auto_wb, rnd_mode;

  sp_operand_fetch dut (
    .clk(clk), .Reset_n(Reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_nA(in_nA), .in_nB(in_nB), .in_nC(in_nC), .in_use(in_use),
    .in_nD(in_nD), .in_wr(in_wr), .in_op(in_op),
    .rf_nA(rf_nA), .rf_nB(rf_nB), .rf_nC(rf_nC),
    .rf_A(rf_A), .rf_B(rf_B), .rf_C(rf_C),
    .wb_nD(wb_nD), .wb_WE(wb_WE),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_A(out_A), .out_B(out_B), .out_C(out_C),
    .out_nD(out_nD), .out_wr(out_wr), .out_op(out_op)
  );

  assign rf_A = rf[rf_nA];
  assign rf_B = rf[rf_nB];
  assign rf_C = rf[rf_nC];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time=%0t limit=500000", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mode) out_ready = ($urandom_range(3) != 0);
  endtask

  // Offer one instruction; on acceptance the model predicts its bundle.
  task automatic issue(input int na, input int nb, input int nc, input int use_m,
                       input int nd, input int wr, input int op, input int wdata);
    exp_t e;
    bit   acc = 0;
    in_nA = RW'(na); in_nB = RW'(nb); in_nC = RW'(nc); in_use = 3'(use_m);
    in_nD = RW'(nd); in_wr = 1'(wr); in_op = OPW'(op); in_valid = 1'b1;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc     = 1;
        e.mask  = 3'(use_m);
        e.a     = arch[na];
        e.b     = arch[nb];
        e.c     = arch[nc];
        e.nD    = RW'(nd);
        e.wr    = 1'(wr);
        e.op    = OPW'(op);
        e.wdata = DW'(wdata);
        exp_q.push_back(e);
        if (wr != 0) arch[nd] = DW'(wdata);
      end
      tick();
    end
    in_valid = 1'b0;
    check("issue_accepted", 32'(acc), 1);
  endtask

  // Ask for the writeback of the outstanding write to idx and wait for its edge.
  task automatic do_wb(input int idx);
    int  c0   = wb_count;
    bit  done = 0;
    req_q.push_back('{idx: idx, spur: 1'b0});
    for (int i = 0; i < 50 && !done; i++) begin
      tick();
      if (wb_count != c0) done = 1;
    end
    check("wb_done", 32'(done), 1);
  endtask

  function automatic logic [NR-1:0] model_pending();
    logic [NR-1:0] m = '0;
    foreach (pend_wb[k]) m[pend_wb[k].idx] = 1'b1;
    return m;
  endfunction

  // Monitor: every dispatched bundle is compared with the next prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (Reset_n && out_valid && out_ready) begin
        check("bundle_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (e.mask[0]) check("out_A", out_A, e.a);
          if (e.mask[1]) check("out_B", out_B, e.b);
          if (e.mask[2]) check("out_C", out_C, e.c);
          check("out_wr", out_wr, e.wr);
          check("out_nD", out_nD, e.nD);
          check("out_op", out_op, e.op);
          if (e.wr) pend_wb.push_back('{idx: e.nD, data: e.wdata, avail: cyc + 1});
        end
      end
    end
  end

  // Writeback driver: directed requests, or random completion plus occasional
  // writebacks to non-pending registers that rewrite the current value.
  initial begin
    int            k, idx;
    bit            go, hit;
    logic [DW-1:0] data;
    for (int i = 0; i < NR; i++) rf[i] = DW'(i * 'h11);
    wb_WE = 1'b0;
    wb_nD = '0;
    forever begin
      @(negedge clk);
      wb_WE = 1'b0;
      go    = 0;
      idx   = 0;
      data  = '0;
      if (!auto_wb) begin
        if (req_q.size() != 0) begin
          if (req_q[0].spur) begin
            idx = req_q[0].idx; data = rf[idx]; go = 1;
            void'(req_q.pop_front());
          end else begin
            for (int j = 0; j < pend_wb.size() && !go; j++)
              if (int'(pend_wb[j].idx) == req_q[0].idx && pend_wb[j].avail <= cyc) begin
                idx = pend_wb[j].idx; data = pend_wb[j].data; go = 1;
                pend_wb.delete(j);
                void'(req_q.pop_front());
              end
          end
        end
      end else if (pend_wb.size() != 0 && $urandom_range(1) == 1) begin
        k = $urandom_range(pend_wb.size() - 1);
        if (pend_wb[k].avail <= cyc) begin
          idx = pend_wb[k].idx; data = pend_wb[k].data; go = 1;
          pend_wb.delete(k);
        end
      end else if ($urandom_range(15) == 0) begin
        idx = $urandom_range(NR - 1);
        hit = 0;
        foreach (pend_wb[j]) if (int'(pend_wb[j].idx) == idx) hit = 1;
        if (!hit) begin data = rf[idx]; go = 1; end
      end
      if (go) begin
        wb_WE = 1'b1;
        wb_nD = RW'(idx);
        @(posedge clk);
        rf[idx] <= data;
        wb_count++;
      end
    end
  end

  initial begin
    exp_t e;
    bit   drained = 0;
    Reset_n = 1'b0; in_valid = 1'b0; in_nA = '0; in_nB = '0; in_nC = '0;
    in_use = '0; in_nD = '0; in_wr = 1'b0; in_op = '0; out_ready = 1'b0;
    auto_wb = 0; rnd_mode = 0;
    for (int i = 0; i < NR; i++) arch[i] = DW'(i * 'h11);

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_A", out_A, 0);
    check("rst_out_nD", out_nD, 0);
    check("rst_out_op", out_op, 0);
    check("rst_pending", dut.pending, 0);
    Reset_n = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 1);

    // Basic fetch and two-edge latency.
    out_ready = 1'b1;
    issue(1, 2, 3, 3'b111, 0, 0, 'h5A, 0);
    check("lat_after_e0", out_valid, 0);
    tick();
    check("lat_after_e1", out_valid, 1);
    tick(); tick();
    check("basic_pending", dut.pending, 0);

    // RAW: reader accepted on the writer's dispatch edge waits for writeback.
    issue(0, 0, 0, 3'b000, 3, 1, 'h11, 'hBEEF);
    issue(3, 0, 0, 3'b001, 0, 0, 'h12, 0);
    check("raw_pending", dut.pending, 16'h0008);
    repeat (3) begin check("raw_stall", out_valid, 0); tick(); end
    do_wb(3);
    check("raw_wb_edge", out_valid, 0);
    tick();
    check("raw_release", out_valid, 1);
    tick();

    // Backpressure: bundle held stable, no new instruction accepted.
    out_ready = 1'b0;
    issue(4, 5, 6, 3'b111, 9, 0, 'h33, 0);
    tick();
    e = exp_q[0];
    repeat (5) begin
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_A", out_A, e.a);
      check("bp_B", out_B, e.b);
      check("bp_C", out_C, e.c);
      check("bp_op", out_op, e.op);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", in_ready, 1);
    tick();

    // Set/clear collision on R5: set wins, reader stalls until a real writeback.
    out_ready = 1'b0;
    issue(0, 0, 0, 3'b000, 5, 1, 'h44, 'h5555);
    tick();
    req_q.push_back('{idx: 5, spur: 1'b1});
    out_ready = 1'b1;
    issue(5, 5, 5, 3'b001, 0, 0, 'h45, 0);
    check("coll_pending", dut.pending, 16'h0020);
    repeat (4) begin check("coll_stall", out_valid, 0); tick(); end
    do_wb(5);
    check("coll_wb_edge", out_valid, 0);
    tick();
    check("coll_release", out_valid, 1);
    tick();

    // WAW on R7 with no sources used.
    issue(0, 0, 0, 3'b000, 7, 1, 'h70, 'h7777);
    issue(0, 0, 0, 3'b000, 7, 1, 'h71, 'h7171);
    repeat (3) begin check("waw_stall", out_valid, 0); tick(); end
    do_wb(7);
    check("waw_wb_edge", out_valid, 0);
    tick();
    check("waw_release", out_valid, 1);
    tick();

    // Reset while a reader of R3 waits with R3 and R7 pending.
    issue(0, 0, 0, 3'b000, 3, 1, 'h30, 'h3333);
    issue(3, 0, 0, 3'b001, 0, 0, 'h31, 0);
    check("pre_rst_pending", dut.pending, model_pending());
    check("pre_rst_mask", model_pending(), 16'h0088);
    #2;
    Reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_pending", dut.pending, 0);
    check("mid_rst_out_A", out_A, 0);
    check("mid_rst_out_op", out_op, 0);
    exp_q.delete();
    pend_wb.delete();
    req_q.delete();
    for (int i = 0; i < NR; i++) arch[i] = rf[i];
    tick();
    Reset_n = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // Randomized traffic with random backpressure and writeback timing.
    auto_wb  = 1;
    rnd_mode = 1;
    repeat (300) begin
      repeat ($urandom_range(2)) tick();
      issue($urandom_range(NR - 1), $urandom_range(NR - 1), $urandom_range(NR - 1),
            $urandom_range(7), $urandom_range(NR - 1), $urandom_range(1),
            $urandom_range(255), $urandom_range(16'hFFFF));
    end
    rnd_mode  = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3000 && !drained; i++) begin
      tick();
      if (exp_q.size() == 0 && pend_wb.size() == 0) drained = 1;
    end
    check("drain_bundles", exp_q.size(), 0);
    check("drain_writes", pend_wb.size(), 0);
    repeat (3) tick();
    check("final_pending", dut.pending, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sp_operand_fetch.md
Name: sp_operand_fetch

Overview:
- Read-side counterpart of the SP core register file: accepts decoded instructions, drives the three register-file read ports and collects the operands.
- Tracks in-flight destination registers in a 16-entry scoreboard, fed by the writeback signals that also drive the register-file write port. Stalls RAW/WAW hazards.
- Hands the operand bundle to the execute stage over a valid/ready handshake.

Parameters:
- DW, 16, data width of one register.
- RW, 4, register index width (2**RW = 16 registers).
- OPW, 8, width of the opaque opcode/control field passed through unchanged.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready.
- in_nA, in_nB, in_nC  in  RW each  source register indices.
- in_use  in  3  source-used mask; bit0=A, bit1=B, bit2=C.
- in_nD  in  RW  destination register index.
- in_wr  in  1  instruction writes in_nD.
- in_op  in  OPW  pass-through control.
- rf_nA, rf_nB, rf_nC  out  RW each  register-file read indices.
- rf_A, rf_B, rf_C  in  DW each  register-file read data (combinational, same cycle).
- wb_nD  in  RW  writeback register index (same net as register-file nD).
- wb_WE  in  1  writeback strobe (same net as register-file RegWE).
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  execute stage accepts bundle.
- out_A, out_B, out_C  out  DW each  latched operands.
- out_nD  out  RW  destination index.
- out_wr  out  1  destination write flag.
- out_op  out  OPW  pass-through control.

Behaviour:
- States: IDLE (empty), WAIT (instruction captured, operands not yet latched), READY (bundle presented).
- Reset (Reset_n low, any state, immediate): state=IDLE, scoreboard=0, out_valid=0, all out_* data/index regs=0. in_ready=0 while Reset_n low.
- in_ready = (state==IDLE) || (state==READY && out_ready).
- Capture: on an accept edge, latch nA/nB/nC/use/nD/wr/op into the holding register and go to WAIT.
  - This happens even when the same edge dispatches the previous bundle.
- rf_nA/B/C always equal the holding-register indices; they are stable for the whole WAIT.
- hazard (evaluated in WAIT, combinational): any of the following, all checked against the scoreboard value of the current cycle (pre-edge):
  - a used source whose pending bit is set;
  - wr && pending[nD].
- A pending bit being cleared by wb_WE in this same cycle still counts as a hazard. The register file does not hold the new value until after the edge.
- No bypass from wb_D.
- WAIT, no hazard: at the edge latch rf_A/B/C into out_A/B/C. Unused sources still latch the rf value; their content is don't-care. Go to READY, out_valid=1.
- WAIT, hazard: remain in WAIT; out_valid=0.
- Minimum latency: accept edge E0 → out_valid high after E1. Peak throughput is one instruction per 2 cycles.
- READY, out_valid && !out_ready: all out_* stable. in_ready=0.
- READY && out_ready (dispatch):
  - if out_wr, set pending[out_nD];
  - next state is WAIT if an instruction is accepted on the same edge, else IDLE.
- Scoreboard clear: wb_WE clears pending[wb_nD] at the edge.
- Same edge, same index, set and clear: set wins. The writeback belongs to an older write and the WAW check guarantees there is at most one outstanding.
- wb_WE to a non-pending register: ignored, no error.
- All 16 registers are scoreboarded identically, including R0.
- in_wr=0 makes in_nD don't-care for hazard checking.

Decomposition:
- Shared package sp_pkg: DW/RW/OPW defaults and the state encoding (IDLE=2'd0, WAIT=2'd1, READY=2'd2).
- Sub-module sp_scoreboard: 16-bit pending vector with set port (idx, en), clear port (idx, en), set-wins priority, async active-low reset, combinational pending outputs.
  - Reusable by the writeback-side unit.

Test Plan:
- Reset, RF R1=0x0011, R2=0x0022, R3=0x0033. Issue A=R1,B=R2,C=R3, use=3'b111, wr=0, op=0x5A → out_valid after 2nd edge with out_A=0x0011, out_B=0x0022, out_C=0x0033, out_op=0x5A; scoreboard stays 0.
- RAW: I1 wr R3 dispatched, I2 reads R3 accepted same edge → I2 holds in WAIT, out_valid=0. Then wb_WE=1, wb_nD=3, wb_D=0xBEEF → I2 out_valid one edge after the wb edge, with out_A=0xBEEF.
- Backpressure: bundle in READY, out_ready=0 for 5 cycles → out_* unchanged, in_ready=0; out_ready=1 → dispatch, in_ready=1 that cycle.
- Set/clear collision: R5 pending; dispatch of a new wr-R5 instruction on the same edge as wb_WE to R5 → pending[5]=1 afterwards. A following reader of R5 stalls until a second wb to R5.
- WAW: R7 pending, issue wr=1 nD=7 with use=0 → stalls in WAIT until wb_nD=7, then proceeds.
- Reset mid-operation: assert Reset_n=0 while in WAIT with pending=0x0088 → immediately out_valid=0, in_ready=0, scoreboard=0. After release, state is IDLE and in_ready=1.
